// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_rr stream multiplexer.
//   MODE_FIXED / MODE_RR : values of the top-level 'mode' input.
//   onehot_to_idx        : converts a one-hot grant (up to MAX_CH bits)
//                          into a binary channel index.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Upper bound on channel count the index helper understands.
    localparam int MAX_CH = 64;
    localparam int IDXW   = $clog2(MAX_CH);

    // OR-reduction of the set bit positions; for a true one-hot vector
    // this is exactly the index, and an all-zero vector maps to 0.
    function automatic logic [IDXW-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | IDXW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : per-channel request vector.
//   ptr : channel with highest priority this cycle.
//   gnt : one-hot grant to the first requester at or after ptr,
//         wrapping modulo NCH; all-zero when nothing requests.
module rr_arbiter #(
    parameter int NCH = 8
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [NCH-1:0]         gnt
);

    localparam int PW = $clog2(NCH);

    logic            found;
    logic [PW-1:0]   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = PW'((32'(ptr) + 32'(k)) % NCH);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// NCH-input valid/ready stream multiplexer with a registered output stage.
// Channels are picked either by an external select (fixed mode) or by a
// fair round-robin arbiter (RR mode).
//
// Optional feature macro: STREAM_MUX_PKT_LOCK_EN
//   When defined, adds in_last/out_last and keeps the grant locked to a
//   channel from its first beat until the beat carrying in_last=1.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   mode                 MODE_FIXED (use sel) or MODE_RR
//   sel                  channel select for fixed mode
//   in_valid/in_ready    per-channel input handshake (in_ready combinational)
//   in_data              channel i at bits [i*N +: N]
//   out_valid/out_ready  output handshake (out_valid registered)
//   out_data, out_ch     registered beat data and its source channel
//   in_last/out_last     packet end markers (lock build only)
//
// Handshake: a beat moves whenever valid && ready are both high at a rising
// edge. in_ready only rises when the output register can take a new beat
// (empty, or being drained this same edge), so a full output stage that the
// consumer stalls holds out_data/out_ch stable and drops every in_ready.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N    = 32,
    parameter int NCH  = 8,
    parameter int SELW = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [NCH-1:0]     in_valid,
    input  logic [NCH*N-1:0]   in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [NCH-1:0]     in_last,
    output logic               out_last,
`endif
    output logic [NCH-1:0]     in_ready,
    output logic               out_valid,
    output logic [N-1:0]       out_data,
    output logic [SELW-1:0]    out_ch,
    input  logic               out_ready
);

    logic [SELW-1:0] rr_ptr;
    logic [NCH-1:0]  rr_gnt;
    logic [NCH-1:0]  fixed_gnt;
    logic [NCH-1:0]  gnt;
    logic [SELW-1:0] gnt_idx;
    logic            load;
    logic            xfer;
    logic            releasing;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req (in_valid),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    // Out-of-range selects (possible when NCH is not a power of two)
    // grant nothing.
    always_comb begin
        fixed_gnt = '0;
        if (int'(sel) < NCH) begin
            fixed_gnt[sel] = in_valid[sel];
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic            lock_active;
    logic [SELW-1:0] lock_ch;
    logic [NCH-1:0]  lock_gnt;

    always_comb begin
        lock_gnt          = '0;
        lock_gnt[lock_ch] = in_valid[lock_ch];
    end

    assign gnt       = lock_active ? lock_gnt
                     : (mode == MODE_RR) ? rr_gnt : fixed_gnt;
    assign releasing = in_last[gnt_idx];
`else
    assign gnt       = (mode == MODE_RR) ? rr_gnt : fixed_gnt;
    assign releasing = 1'b1;
`endif

    // Nothing is accepted while reset is asserted.
    assign load     = rst_n && (!out_valid || out_ready);
    assign in_ready = gnt & {NCH{load}};
    assign xfer     = load && (|gnt);
    assign gnt_idx  = SELW'(onehot_to_idx(MAX_CH'(gnt)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= in_data[int'(gnt_idx)*N +: N];
                    out_ch   <= gnt_idx;
                end
            end
            // Only a packet-ending transfer in RR mode moves the pointer.
            if (xfer && releasing && (mode == MODE_RR)) begin
                rr_ptr <= (gnt_idx == SELW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_ch     <= '0;
            out_last    <= 1'b0;
        end else if (xfer) begin
            lock_active <= !releasing;
            lock_ch     <= gnt_idx;
            out_last    <= releasing;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  localparam int N    = 32;
  localparam int NCH  = 8;
  localparam int SELW = 3;
  localparam int W    = N + SELW + 1;

  logic             clk;
  logic             rst_n;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic [NCH-1:0]   in_valid;
  logic [NCH*N-1:0] in_data;
  logic [NCH-1:0]   in_last;
  logic             out_last;
  logic [NCH-1:0]   in_ready;
  logic             out_valid;
  logic [N-1:0]     out_data;
  logic [SELW-1:0]  out_ch;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  // scoreboard: {last, ch, data}
  logic [W-1:0] exp_q[$];

  // reference model state
  logic            m_ov;
  int              m_ptr;
  logic            m_lock;
  int              m_lock_ch;

  stream_mux_rr #(.N(N), .NCH(NCH), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

`ifndef STREAM_MUX_PKT_LOCK_EN
  assign out_last = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NCH; i++) in_data[i*N +: N] = $urandom;
  endtask

  // model arbitration: returns granted channel or -1
  function automatic int model_pick();
    int c;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
`endif
    if (mode) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (in_valid[c]) return c;
      end
      return -1;
    end
    if (int'(sel) < NCH && in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  // monitor / scoreboard: inputs are stable at the falling edge
  always @(negedge clk) begin
    int           g;
    logic         m_load;
    logic [NCH-1:0] exp_rdy;
    logic [W-1:0] e;
    logic         lst;
    if (!rst_n) begin
      check("rst_in_ready", 64'(in_ready), 64'(0));
      m_ov = 1'b0;
      m_ptr = 0;
      m_lock = 1'b0;
      m_lock_ch = 0;
      exp_q.delete();
    end else begin
      check("out_valid", 64'(out_valid), 64'(m_ov));
      m_load = !m_ov || out_ready;
      g = model_pick();
      exp_rdy = '0;
      if (g >= 0 && m_load) exp_rdy[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (m_ov && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_data", 64'(out_data), 64'(e[N-1:0]));
        check("sb_ch", 64'(out_ch), 64'(e[N+SELW-1:N]));
        check("sb_last", 64'(out_last), 64'(e[W-1]));
      end
      if (m_load) begin
        m_ov = (g >= 0);
        if (g >= 0) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
          lst = in_last[g];
`else
          lst = 1'b1;
`endif
          exp_q.push_back({
`ifdef STREAM_MUX_PKT_LOCK_EN
                           lst,
`else
                           1'b0,
`endif
                           SELW'(g), in_data[g*N +: N]});
          if (lst && mode) m_ptr = (g + 1) % NCH;
          m_lock = !lst;
          m_lock_ch = g;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    mode = 1'b1;
    sel = '0;
    in_valid = 8'hFF;
    in_last = '1;
    out_ready = 1'b1;
    in_data = '0;
    rand_data();

    // reset
    tick();
    tick();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_ch", 64'(out_ch), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_in_ready_d", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    #1;
    check("rr_first_grant", 64'(in_ready), 64'(8'h01));

    // fixed mode, switched before the edge so no RR transfer happens
    mode = 1'b0;
    sel = 3'd3;
    in_valid = 8'h08;
    in_data[3*N +: N] = 32'hDEADBEEF;
    #1;
    check("fix_in_ready", 64'(in_ready), 64'(8'h08));
    tick();
    check("fix_out_valid", 64'(out_valid), 64'(1));
    check("fix_out_data", 64'(out_data), 64'(32'hDEADBEEF));
    check("fix_out_ch", 64'(out_ch), 64'(3));
    sel = 3'd2;
    #1;
    check("fix_no_grant", 64'(in_ready), 64'(0));
    tick();
    check("fix_idle_valid", 64'(out_valid), 64'(0));
    check("fix_idle_ch_hold", 64'(out_ch), 64'(3));

    // RR fairness, rr_ptr is still 0
    mode = 1'b1;
    in_valid = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      rand_data();
      tick();
      check("fair_valid", 64'(out_valid), 64'(1));
      check("fair_ch", 64'(out_ch), 64'(i % NCH));
    end

    // backpressure with a ch5 beat held
    in_valid = 8'h20;
    in_data[5*N +: N] = 32'h12345678;
    tick();
    out_ready = 1'b0;
    in_valid = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      #1;
      check("bp_in_ready", 64'(in_ready), 64'(0));
      tick();
      check("bp_data", 64'(out_data), 64'(32'h12345678));
      check("bp_ch", 64'(out_ch), 64'(5));
      check("bp_valid", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'(8'h40));
    tick();
    check("bp_next_ch", 64'(out_ch), 64'(6));
    check("bp_no_bubble", 64'(out_valid), 64'(1));

    // wrap / sparse, rr_ptr is 7 after the ch6 transfer
    in_valid = 8'h81;
    #1;
    check("wrap_ready", 64'(in_ready), 64'(8'h80));
    tick();
    check("wrap_ch7", 64'(out_ch), 64'(7));
    tick();
    check("wrap_ch0", 64'(out_ch), 64'(0));
    tick();
    check("wrap_ch7b", 64'(out_ch), 64'(7));

    // random traffic, checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      mode = 1'($urandom_range(0, 1));
      sel = SELW'($urandom_range(0, NCH-1));
      in_valid = NCH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_PKT_LOCK_EN
      in_last = NCH'($urandom);
`endif
      rand_data();
      tick();
    end

    // drain
    in_valid = '0;
    out_ready = 1'b1;
    in_last = '1;
    tick();
    tick();
    check("drain_valid", 64'(out_valid), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

`ifdef STREAM_MUX_PKT_LOCK_EN
    // packet lock: ch2 sends three beats
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mode = 1'b1;
    in_valid = 8'h04;
    in_last = 8'h00;
    rand_data();
    tick();
    check("lock_b1", 64'(out_ch), 64'(2));
    in_valid = 8'hFF;
    rand_data();
    tick();
    check("lock_b2", 64'(out_ch), 64'(2));
    in_last = 8'h04;
    rand_data();
    tick();
    check("lock_b3", 64'(out_ch), 64'(2));
    check("lock_last", 64'(out_last), 64'(1));
    in_last = '1;
    rand_data();
    tick();
    check("lock_next", 64'(out_ch), 64'(3));
    in_valid = '0;
    tick();
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
